// File: rtl/output_sample_fifo_pkg.sv
// Shared types and the write-path conversion for the output sample FIFO.
// The sample tuple is packed so the FIFO can store it as a plain bit vector.
package output_sample_fifo_pkg;

  localparam int N_CH  = 4;
  localparam int W     = 16;
  localparam int OUT_W = 12;

  localparam logic signed [W-1:0] SAT_MAX = W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  typedef logic [N_CH-1:0][OUT_W-1:0] sample_t;

  typedef enum logic {
    PRIMING,
    RUNNING
  } state_t;

  // Arithmetic shift keeps the sign, then clamp into the DAC range.
  function automatic logic [OUT_W-1:0] sat_shift(input logic signed [W-1:0] x,
                                                 input int unsigned shift);
    logic signed [W-1:0] s;
    s = x >>> shift;
    if (s > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/output_sample_fifo_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a slot
// in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/output_sample_fifo.sv
// Captures network results, rescales them to DAC width, and releases one sample
// per sample_tick once enough entries have been primed.
module output_sample_fifo
  import output_sample_fifo_pkg::*;
#(
  parameter int SHIFT = 4,
  parameter int DEPTH = 4,
  parameter int PRIME = 2,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [W-1:0]         in_d [0:3],
  input  logic                        in_v,
  input  logic                        sample_tick,
  output logic signed [OUT_W-1:0]     out_d [0:3],
  output logic                        out_v,
  output logic                        underrun,
  output logic [$clog2(DEPTH):0]      level,
  output logic [CNT_W-1:0]            overflow_cnt,
  output logic [CNT_W-1:0]            underflow_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  sample_t          out_data_q, out_data_d;
  sample_t          wr_data, rd_data;
  logic             out_v_q, out_v_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] ovf_q, ovf_d, unf_q, unf_d;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0]    fifo_level;

  always_comb begin
    wr_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_data[c] = sat_shift(in_d[c], SHIFT);
    end
  end

  assign fifo_pop = sample_tick && (state_q == RUNNING) && !fifo_empty;

  sync_fifo #(
    .WIDTH($bits(sample_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (in_v),
    .pop_i  (fifo_pop),
    .wdata_i(wr_data),
    .rdata_o(rd_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  // An empty tick while running repeats the previous sample rather than glitching.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_v_d    = sample_tick;
    underrun_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (state_q == PRIMING) begin
      if (sample_tick) out_data_d = '0;
      if (fifo_level >= LW'(PRIME)) state_d = RUNNING;
    end else if (sample_tick) begin
      if (!fifo_empty) begin
        out_data_d = rd_data;
      end else begin
        underrun_d = 1'b1;
        if (unf_q != '1) unf_d = unf_q + 1'b1;
      end
    end
    if (in_v && fifo_full && !fifo_pop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRIMING;
      out_data_q <= '0;
      out_v_q    <= 1'b0;
      underrun_q <= 1'b0;
      ovf_q      <= '0;
      unf_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_v_q    <= out_v_d;
      underrun_q <= underrun_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      out_d[c] = out_data_q[c];
    end
  end

  assign out_v         = out_v_q;
  assign underrun      = underrun_q;
  assign level         = fifo_level;
  assign overflow_cnt  = ovf_q;
  assign underflow_cnt = unf_q;

endmodule

// File: tb/tb_output_sample_fifo.sv
// Directed bench for output_sample_fifo with a queue-based reference model of the
// buffered samples, priming state and counters.
module tb_output_sample_fifo;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_d [0:3];
  logic               in_v;
  logic               sample_tick;
  logic signed [11:0] out_d [0:3];
  logic               out_v;
  logic               underrun;
  logic [2:0]         level;
  logic [7:0]         overflow_cnt;
  logic [7:0]         underflow_cnt;

  int total = 0;
  int bad   = 0;

  logic [47:0] sb [$];
  bit          m_run;
  bit          m_unr;
  int          m_last [4];
  int          m_ovf, m_unf;

  output_sample_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .in_d         (in_d),
    .in_v         (in_v),
    .sample_tick  (sample_tick),
    .out_d        (out_d),
    .out_v        (out_v),
    .underrun     (underrun),
    .level        (level),
    .overflow_cnt (overflow_cnt),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic int conv(input int v);
    int s;
    s = v >>> 4;
    if (s > 2047) return 2047;
    if (s < -2048) return -2048;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("underrun", underrun, m_unr);
    for (int c = 0; c < 4; c++) checkOutput($sformatf("out_d[%0d]", c), out_d[c], m_last[c]);
    checkOutput("level", level, sb.size());
    checkOutput("overflow_cnt", overflow_cnt, m_ovf);
    checkOutput("underflow_cnt", underflow_cnt, m_unf);
  endtask

  // One clock of stimulus; the model is advanced with pre-edge state, then compared.
  task automatic applyStimulus(input bit v, input int d0, input int d1, input int d2,
                               input int d3, input bit tick);
    int          vals [4];
    int          lvl_pre;
    logic [47:0] w;
    logic [47:0] h;
    vals = '{d0, d1, d2, d3};
    @(negedge clk);
    for (int c = 0; c < 4; c++) in_d[c] = 16'(vals[c]);
    in_v        = v;
    sample_tick = tick;
    @(posedge clk);
    #1;
    lvl_pre = sb.size();
    m_unr   = 1'b0;
    for (int c = 0; c < 4; c++) w[c*12 +: 12] = 12'(conv(vals[c]));
    if (tick) begin
      if (!m_run) begin
        m_last = '{0, 0, 0, 0};
      end else if (sb.size() > 0) begin
        h = sb.pop_front();
        for (int c = 0; c < 4; c++) m_last[c] = int'($signed(h[c*12 +: 12]));
      end else begin
        m_unr = 1'b1;
        if (m_unf < 255) m_unf++;
      end
    end
    if (v) begin
      if (sb.size() < 4) sb.push_back(w);
      else if (m_ovf < 255) m_ovf++;
    end
    if (!m_run && lvl_pre >= 2) m_run = 1'b1;
    checkOutput("out_v", out_v, tick);
    checkModel();
    in_v        = 1'b0;
    sample_tick = 1'b0;
  endtask

  // Reset is applied with tick and in_v both high to show neither leaks through.
  task automatic applyReset();
    @(negedge clk);
    rst         = 1'b1;
    in_v        = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    m_run  = 1'b0;
    m_unr  = 1'b0;
    m_last = '{0, 0, 0, 0};
    m_ovf  = 0;
    m_unf  = 0;
    checkOutput("reset_out_v", out_v, 1'b0);
    checkModel();
    rst         = 1'b0;
    in_v        = 1'b0;
    sample_tick = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_v        = 1'b0;
    sample_tick = 1'b0;
    for (int c = 0; c < 4; c++) in_d[c] = '0;
    applyReset();

    $display("[TB] idle ticks while priming");
    repeat (3) applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("idle_underflow", underflow_cnt, 0);

    $display("[TB] priming and first underrun");
    applyStimulus(1'b1, 16, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 32, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("prime_first_ch0", out_d[0], 1);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("prime_second_ch0", out_d[0], 2);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("prime_underrun", underrun, 1);
    checkOutput("prime_hold_ch0", out_d[0], 2);
    checkOutput("prime_underflow", underflow_cnt, 1);

    $display("[TB] saturation");
    applyReset();
    applyStimulus(1'b1, 32767, -32768, 160, -17, 1'b0);
    applyStimulus(1'b1, 48, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("sat_ch0", out_d[0], 2047);
    checkOutput("sat_ch1", out_d[1], -2048);
    checkOutput("sat_ch2", out_d[2], 10);
    checkOutput("sat_ch3", out_d[3], -2);

    $display("[TB] overflow and simultaneous push/pop");
    applyReset();
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 16 * k, -16 * k, 0, 0, 1'b0);
    checkOutput("ovf_level", level, 4);
    checkOutput("ovf_count", overflow_cnt, 2);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 112, 5, 0, 0, 1'b1);
    checkOutput("full_both_ch0", out_d[0], 1);
    checkOutput("full_both_level", level, 4);
    checkOutput("full_both_ovf", overflow_cnt, 2);
    repeat (4) applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("drain_last_ch0", out_d[0], 7);
    applyStimulus(1'b1, 128, 0, 0, 0, 1'b1);
    checkOutput("empty_both_underrun", underrun, 1);
    checkOutput("empty_both_level", level, 1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 144, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 160, 0, 0, 0, 1'b0);
    checkOutput("pre_reset_level", level, 3);
    applyReset();
    checkOutput("post_reset_level", level, 0);
    applyStimulus(1'b1, 176, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("post_reset_ch0", out_d[0], 0);
    checkOutput("post_reset_level1", level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
